// File: rtl/board_link.sv
// ============================================================================
// board_link : typed 4-phase req/ack message link for the two-board guessing game
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module board_link #(
  parameter int ID_W        = 4,
  parameter int N_PERSONS   = 9,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ID_W-1:0] my_person,
  input  logic            send_person,
  input  logic            guess_valid,
  input  logic [ID_W-1:0] guess_id,
  input  logic            reset_req,
  input  logic            clr_result,
  output logic [ID_W+1:0] tx_data,
  output logic            tx_req,
  input  logic            tx_ack_in,
  input  logic [ID_W+1:0] rx_data,
  input  logic            rx_req,
  output logic            rx_ack,
  output logic [1:0]      result,
  output logic [ID_W-1:0] peer_person,
  output logic            peer_person_valid,
  output logic            peer_reset,
  output logic            link_busy,
  output logic            link_err
);

  localparam int DW = ID_W + 2;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [ID_W:0]   MAX_ID    = (ID_W+1)'(N_PERSONS);

  localparam logic [1:0] MSG_PERSON = 2'b01;
  localparam logic [1:0] MSG_RESULT = 2'b10;
  localparam logic [1:0] MSG_RESET  = 2'b11;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b10;
  localparam logic [1:0] RES_LOSE = 2'b01;

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_REQ  = 2'd1;
  localparam logic [1:0] TX_REL  = 2'd2;
  localparam logic [0:0] RX_IDLE = 1'b0;
  localparam logic [0:0] RX_ACK  = 1'b1;

  logic [SYNC_STAGES-1:0]         ack_sync_q, ack_sync_d, req_sync_q, req_sync_d;
  logic [SYNC_STAGES-1:0][DW-1:0] data_sync_q, data_sync_d;

  logic [1:0]      tx_state_q, tx_state_d;
  logic [0:0]      rx_state_q, rx_state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [DW-1:0]   tx_data_q, tx_data_d;
  logic            link_err_q, link_err_d;
  logic            pend_rst_q, pend_rst_d, pend_res_q, pend_res_d, pend_per_q, pend_per_d;
  logic            res_lose_q, res_lose_d;
  logic [1:0]      result_q, result_d;
  logic [ID_W-1:0] peer_person_q, peer_person_d;
  logic            ppv_q, ppv_d;
  logic            peer_reset_q, peer_reset_d;
  logic            guess_pend_q, guess_pend_d;
  logic [ID_W-1:0] guess_id_q, guess_id_d;

  logic            ack_s, req_s;
  logic [DW-1:0]   data_s;
  logic            rx_fire, rx_person, rx_result, rx_reset, wipe, guess_ok, eval, win;
  logic [ID_W-1:0] rx_pay, res_pay;

  always_comb begin
    ack_sync_d  = {ack_sync_q[SYNC_STAGES-2:0], tx_ack_in};
    req_sync_d  = {req_sync_q[SYNC_STAGES-2:0], rx_req};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], rx_data};
    ack_s  = ack_sync_q[SYNC_STAGES-1];
    req_s  = req_sync_q[SYNC_STAGES-1];
    data_s = data_sync_q[SYNC_STAGES-1];
  end

  // Decode only on the IDLE->ACK transition so each handshake acts once.
  always_comb begin
    rx_fire   = (rx_state_q == RX_IDLE) && req_s;
    rx_pay    = data_s[ID_W-1:0];
    rx_person = rx_fire && (data_s[DW-1:DW-2] == MSG_PERSON);
    rx_result = rx_fire && (data_s[DW-1:DW-2] == MSG_RESULT);
    rx_reset  = rx_fire && (data_s[DW-1:DW-2] == MSG_RESET);
    rx_state_d = rx_state_q;
    if (rx_state_q == RX_IDLE && req_s)       rx_state_d = RX_ACK;
    else if (rx_state_q == RX_ACK && !req_s)  rx_state_d = RX_IDLE;
  end

  always_comb begin
    wipe     = rx_reset || reset_req;
    guess_ok = guess_valid && (result_q == RES_NONE) && (guess_id != '0) &&
               ({1'b0, guess_id} <= MAX_ID);
    eval     = guess_pend_q && ppv_q && (result_q == RES_NONE) && !wipe;
    win      = (guess_id_q == peer_person_q);

    result_d      = result_q;
    peer_person_d = peer_person_q;
    ppv_d         = ppv_q;
    guess_pend_d  = guess_pend_q;
    guess_id_d    = guess_id_q;
    pend_rst_d    = pend_rst_q;
    pend_res_d    = pend_res_q;
    pend_per_d    = pend_per_q;
    res_lose_d    = res_lose_q;
    peer_reset_d  = rx_reset;

    if (tx_state_q == TX_REQ && ack_s) begin
      case (tx_data_q[DW-1:DW-2])
        MSG_RESET:  pend_rst_d = 1'b0;
        MSG_RESULT: pend_res_d = 1'b0;
        MSG_PERSON: pend_per_d = 1'b0;
        default:    ;
      endcase
    end

    if (eval) begin
      result_d     = win ? RES_WIN : RES_LOSE;
      pend_res_d   = 1'b1;
      res_lose_d   = !win;
      guess_pend_d = 1'b0;
    end else if (guess_pend_q && result_q != RES_NONE) begin
      guess_pend_d = 1'b0;
    end
    if (guess_ok) begin
      guess_pend_d = 1'b1;
      guess_id_d   = guess_id;
    end
    if (rx_person) begin
      peer_person_d = rx_pay;
      ppv_d         = 1'b1;
    end
    if (rx_result && result_q == RES_NONE && !eval)
      result_d = rx_pay[0] ? RES_WIN : RES_LOSE;
    if (clr_result) begin
      result_d     = RES_NONE;
      guess_pend_d = 1'b0;
    end
    // Reset clears last so it overrides any result set in the same cycle.
    if (wipe) begin
      result_d     = RES_NONE;
      ppv_d        = 1'b0;
      guess_pend_d = 1'b0;
      pend_res_d   = 1'b0;
      pend_per_d   = 1'b0;
    end
    if (reset_req)   pend_rst_d = 1'b1;
    if (send_person) pend_per_d = 1'b1;
  end

  always_comb begin
    res_pay    = '0;
    res_pay[0] = res_lose_q;
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    link_err_d = link_err_q;
    timer_d    = timer_q + TW'(1);
    case (tx_state_q)
      TX_IDLE: begin
        timer_d = '0;
        if (pend_rst_q)      tx_data_d = {MSG_RESET, {ID_W{1'b0}}};
        else if (pend_res_q) tx_data_d = {MSG_RESULT, res_pay};
        else if (pend_per_q) tx_data_d = {MSG_PERSON, my_person};
        if (pend_rst_q || pend_res_q || pend_per_q) tx_state_d = TX_REQ;
      end
      TX_REQ, TX_REL: begin
        if ((tx_state_q == TX_REQ) == ack_s) begin
          tx_state_d = (tx_state_q == TX_REQ) ? TX_REL : TX_IDLE;
          timer_d    = '0;
        end else if (timer_q == TOUT_LAST) begin
          tx_state_d = TX_IDLE;
          link_err_d = 1'b1;
          timer_d    = '0;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_q    <= '0;
      req_sync_q    <= '0;
      data_sync_q   <= '0;
      tx_state_q    <= TX_IDLE;
      rx_state_q    <= RX_IDLE;
      timer_q       <= '0;
      tx_data_q     <= '0;
      link_err_q    <= 1'b0;
      pend_rst_q    <= 1'b0;
      pend_res_q    <= 1'b0;
      pend_per_q    <= 1'b0;
      res_lose_q    <= 1'b0;
      result_q      <= RES_NONE;
      peer_person_q <= '0;
      ppv_q         <= 1'b0;
      peer_reset_q  <= 1'b0;
      guess_pend_q  <= 1'b0;
      guess_id_q    <= '0;
    end else begin
      ack_sync_q    <= ack_sync_d;
      req_sync_q    <= req_sync_d;
      data_sync_q   <= data_sync_d;
      tx_state_q    <= tx_state_d;
      rx_state_q    <= rx_state_d;
      timer_q       <= timer_d;
      tx_data_q     <= tx_data_d;
      link_err_q    <= link_err_d;
      pend_rst_q    <= pend_rst_d;
      pend_res_q    <= pend_res_d;
      pend_per_q    <= pend_per_d;
      res_lose_q    <= res_lose_d;
      result_q      <= result_d;
      peer_person_q <= peer_person_d;
      ppv_q         <= ppv_d;
      peer_reset_q  <= peer_reset_d;
      guess_pend_q  <= guess_pend_d;
      guess_id_q    <= guess_id_d;
    end
  end

  assign tx_data           = tx_data_q;
  assign tx_req            = (tx_state_q == TX_REQ);
  assign link_busy         = (tx_state_q != TX_IDLE);
  assign link_err          = link_err_q;
  assign rx_ack            = (rx_state_q == RX_ACK);
  assign result            = result_q;
  assign peer_person       = peer_person_q;
  assign peer_person_valid = ppv_q;
  assign peer_reset        = peer_reset_q;

endmodule

`default_nettype wire

// File: tb/tb_board_link.sv
// ============================================================================
// tb_board_link : directed self-checking bench for board_link
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module tb_board_link;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] my_person = 4'd5;
  logic       send_person = 1'b0;
  logic       guess_valid = 1'b0;
  logic [3:0] guess_id = 4'd0;
  logic       reset_req = 1'b0;
  logic       clr_result = 1'b0;
  logic [5:0] tx_data;
  logic       tx_req;
  logic       tx_ack_in = 1'b0;
  logic [5:0] rx_data = 6'd0;
  logic       rx_req = 1'b0;
  logic       rx_ack;
  logic [1:0] result;
  logic [3:0] peer_person;
  logic       peer_person_valid;
  logic       peer_reset;
  logic       link_busy;
  logic       link_err;

  int errors = 0;
  int checks = 0;
  int pr_cnt = 0;
  bit ack_en = 1'b1;
  logic [5:0] sent_q[$];

  board_link #(.ID_W(4), .N_PERSONS(9), .SYNC_STAGES(2), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .my_person(my_person), .send_person(send_person),
    .guess_valid(guess_valid), .guess_id(guess_id), .reset_req(reset_req),
    .clr_result(clr_result), .tx_data(tx_data), .tx_req(tx_req), .tx_ack_in(tx_ack_in),
    .rx_data(rx_data), .rx_req(rx_req), .rx_ack(rx_ack), .result(result),
    .peer_person(peer_person), .peer_person_valid(peer_person_valid),
    .peer_reset(peer_reset), .link_busy(link_busy), .link_err(link_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (peer_reset) pr_cnt++;

  // Peer receiver: raises ack 3 cycles after seeing req, logs the message, drops ack after req falls.
  initial begin : peer_rx
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (!tx_ack_in) begin
        if (ack_en && tx_req) begin
          wait_cnt++;
          if (wait_cnt >= 3) begin
            tx_ack_in = 1'b1;
            sent_q.push_back(tx_data);
            wait_cnt = 0;
          end
        end else begin
          wait_cnt = 0;
        end
      end else if (!tx_req) begin
        tx_ack_in = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_msg(input logic [1:0] t, input logic [3:0] p);
    int n;
    rx_data = {t, p};
    rx_req  = 1'b1;
    n = 0;
    while (!rx_ack && n < 20) begin @(negedge clk); n++; end
    check("rx_ack_rise", {31'd0, rx_ack}, 32'd1);
    rx_req = 1'b0;
    n = 0;
    while (rx_ack && n < 20) begin @(negedge clk); n++; end
    check("rx_ack_fall", {31'd0, rx_ack}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_sent(input int target);
    int n;
    n = 0;
    while ((sent_q.size() < target || link_busy) && n < 300) begin @(negedge clk); n++; end
    check("tx_done", sent_q.size(), target);
  endtask

  task automatic guess(input logic [3:0] id);
    guess_valid = 1'b1;
    guess_id    = id;
    @(negedge clk);
    guess_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_result = 1'b1;
    @(negedge clk);
    clr_result = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    int n;
    int hi;
    repeat (3) @(negedge clk);
    check("rst_tx_req", {31'd0, tx_req}, 32'd0);
    check("rst_tx_data", {26'd0, tx_data}, 32'd0);
    check("rst_rx_ack", {31'd0, rx_ack}, 32'd0);
    check("rst_result", {30'd0, result}, 32'd0);
    check("rst_ppv", {31'd0, peer_person_valid}, 32'd0);
    check("rst_busy_err", {30'd0, link_busy, link_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Send own person 5
    send_person = 1'b1;
    @(negedge clk);
    send_person = 1'b0;
    check("per_idle", {31'd0, tx_req}, 32'd0);
    @(negedge clk);
    check("per_req", {31'd0, tx_req}, 32'd1);
    check("per_data", {26'd0, tx_data}, 32'h15);
    wait_sent(1);
    check("per_sent", {26'd0, sent_q[0]}, 32'h15);
    repeat (20) @(negedge clk);
    check("per_once", sent_q.size(), 1);

    // Peer person 7, winning guess
    send_msg(2'b01, 4'd7);
    check("peer_person", {28'd0, peer_person}, 32'd7);
    check("peer_valid", {31'd0, peer_person_valid}, 32'd1);
    guess(4'd7);
    check("win_lat", {30'd0, result}, 32'd0);
    @(negedge clk);
    check("win", {30'd0, result}, 32'b10);
    wait_sent(2);
    check("win_msg", {26'd0, sent_q[1]}, 32'h20);

    // Losing guess
    pulse_clr();
    check("clr", {30'd0, result}, 32'd0);
    guess(4'd3);
    @(negedge clk);
    check("lose", {30'd0, result}, 32'b01);
    wait_sent(3);
    check("lose_msg", {26'd0, sent_q[2]}, 32'h21);

    // Out-of-range guesses ignored, upper bound accepted
    pulse_clr();
    guess(4'd0);
    repeat (3) @(negedge clk);
    check("guess0", {30'd0, result}, 32'd0);
    guess(4'd10);
    repeat (3) @(negedge clk);
    check("guess10", {30'd0, result}, 32'd0);
    check("no_msg", sent_q.size(), 3);
    guess(4'd9);
    @(negedge clk);
    check("guess9", {30'd0, result}, 32'b01);
    wait_sent(4);
    check("g9_msg", {26'd0, sent_q[3]}, 32'h21);
    pulse_clr();

    // Reset, person and result trigger collide
    guess_valid = 1'b1;
    guess_id    = 4'd2;
    @(negedge clk);
    guess_valid = 1'b0;
    reset_req   = 1'b1;
    send_person = 1'b1;
    @(negedge clk);
    reset_req   = 1'b0;
    send_person = 1'b0;
    check("coll_result", {30'd0, result}, 32'd0);
    check("coll_ppv", {31'd0, peer_person_valid}, 32'd0);
    base = 4;
    wait_sent(base + 2);
    check("coll_first", {26'd0, sent_q[base]}, 32'h30);
    check("coll_second", {26'd0, sent_q[base+1]}, 32'h15);
    repeat (30) @(negedge clk);
    check("coll_count", sent_q.size(), base + 2);
    check("coll_result2", {30'd0, result}, 32'd0);

    // Received RESULT and RESET
    send_msg(2'b01, 4'd2);
    check("peer2", {28'd0, peer_person}, 32'd2);
    send_msg(2'b10, 4'd1);
    check("rx_result", {30'd0, result}, 32'b10);
    send_msg(2'b11, 4'd0);
    check("rxrst_result", {30'd0, result}, 32'd0);
    check("rxrst_ppv", {31'd0, peer_person_valid}, 32'd0);
    check("peer_reset_cnt", pr_cnt, 1);
    check("rxrst_nomsg", sent_q.size(), base + 2);

    // Timeout and retry
    ack_en = 1'b0;
    send_person = 1'b1;
    @(negedge clk);
    send_person = 1'b0;
    n = 0;
    while (!tx_req && n < 10) begin @(negedge clk); n++; end
    check("to_req", {31'd0, tx_req}, 32'd1);
    hi = 1;
    while (hi < 100) begin
      @(negedge clk);
      if (!tx_req) break;
      hi++;
    end
    check("to_cycles", hi, 16);
    check("to_err", {31'd0, link_err}, 32'd1);
    n = 0;
    while (!tx_req && n < 10) begin @(negedge clk); n++; end
    check("to_retry", {31'd0, tx_req}, 32'd1);
    ack_en = 1'b1;
    wait_sent(base + 3);
    check("to_msg", {26'd0, sent_q[base+2]}, 32'h15);
    check("err_sticky", {31'd0, link_err}, 32'd1);

    // Asynchronous reset while in REQ
    ack_en = 1'b0;
    send_person = 1'b1;
    @(negedge clk);
    send_person = 1'b0;
    n = 0;
    while (!tx_req && n < 10) begin @(negedge clk); n++; end
    check("ar_req", {31'd0, tx_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_tx_req", {31'd0, tx_req}, 32'd0);
    check("ar_busy_err", {30'd0, link_busy, link_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("ar_quiet", {31'd0, tx_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
